// File: rtl/simd_tmp_reader.sv
// Indexed read port for the SIMD temporary delay buffer, with fill tracking and a registered valid/ack output.
// Optional build macro SIMD_TMP_READER_BYPASS_EN: reads coincident with a shift see the post-shift view.
module simd_tmp_reader #(
    parameter int VSIZE     = 4,
    parameter int TDBW      = 8,
    parameter int TBUF_SIZE = 4,
    localparam int IBW      = (TBUF_SIZE > 1) ? $clog2(TBUF_SIZE) : 1,
    localparam int CBW      = $clog2(TBUF_SIZE + 1)
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic                                        i_clear,
    input  logic                                        i_we,
    input  logic [TBUF_SIZE-1:0][VSIZE-1:0][TDBW-1:0]   i_rdatas,
`ifdef SIMD_TMP_READER_BYPASS_EN
    input  logic [VSIZE-1:0][TDBW-1:0]                  i_wdata,
`endif
    input  logic                                        i_rd_rdy,
    output logic                                        o_rd_ack,
    input  logic [IBW-1:0]                              i_rd_idx,
    output logic                                        o_dat_rdy,
    input  logic                                        i_dat_ack,
    output logic [VSIZE-1:0][TDBW-1:0]                  o_dat,
    output logic                                        o_dat_err,
    output logic [CBW-1:0]                              o_fill
);

    logic [CBW-1:0]              fill;
    logic [VSIZE-1:0][TDBW-1:0]  sel_dat;
    logic                        sel_err;
    int                          chk_fill;

    function automatic logic [CBW-1:0] sat_inc(input logic [CBW-1:0] v);
        if (int'(v) >= TBUF_SIZE) return v;
        return v + CBW'(1);
    endfunction

    // Fill counter: clear dominates, shifts count up to the buffer depth.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     fill <= '0;
        else if (i_clear) fill <= '0;
        else if (i_we)    fill <= sat_inc(fill);
    end

    assign o_fill   = fill;
    assign o_rd_ack = i_rd_rdy && (!o_dat_rdy || i_dat_ack);

    // Entry select; out-of-range indices fall through to zero data.
    always_comb begin
        sel_dat  = '0;
        chk_fill = int'(fill);
        for (int k = 0; k < TBUF_SIZE; k++) begin
            if (int'(i_rd_idx) == k) sel_dat = i_rdatas[k];
        end
`ifdef SIMD_TMP_READER_BYPASS_EN
        if (i_we) begin
            if (int'(i_rd_idx) == 0) sel_dat = i_wdata;
            for (int k = 1; k < TBUF_SIZE; k++) begin
                if (int'(i_rd_idx) == k) sel_dat = i_rdatas[k-1];
            end
            chk_fill = i_clear ? 1 : ((int'(fill) + 1 > TBUF_SIZE) ? TBUF_SIZE : int'(fill) + 1);
        end
`endif
        sel_err = (int'(i_rd_idx) >= TBUF_SIZE) || (int'(i_rd_idx) >= chk_fill);
    end

    // Output stage: data/err load only on accept, valid drops when consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dat_rdy <= 1'b0;
            o_dat     <= '0;
            o_dat_err <= 1'b0;
        end else if (o_rd_ack) begin
            o_dat_rdy <= 1'b1;
            o_dat     <= sel_dat;
            o_dat_err <= sel_err;
        end else if (i_dat_ack) begin
            o_dat_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simd_tmp_reader.sv
// Directed bench for simd_tmp_reader (TBUF_SIZE=4, VSIZE=4, TDBW=8); honours SIMD_TMP_READER_BYPASS_EN.
module tb_simd_tmp_reader;

    localparam int VSIZE = 4;
    localparam int TDBW  = 8;
    localparam int TBUF  = 4;

    logic                                   clk;
    logic                                   rst_n;
    logic                                   clear;
    logic                                   we;
    logic [TBUF-1:0][VSIZE-1:0][TDBW-1:0]   rdatas;
    logic [VSIZE-1:0][TDBW-1:0]             wdata;
    logic                                   rd_rdy;
    logic                                   rd_ack;
    logic [1:0]                             rd_idx;
    logic                                   dat_rdy;
    logic                                   dat_ack;
    logic [VSIZE-1:0][TDBW-1:0]             dat;
    logic                                   dat_err;
    logic [2:0]                             fill;

    int checks   = 0;
    int failures = 0;

    simd_tmp_reader #(.VSIZE(VSIZE), .TDBW(TDBW), .TBUF_SIZE(TBUF)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_clear   (clear),
        .i_we      (we),
        .i_rdatas  (rdatas),
`ifdef SIMD_TMP_READER_BYPASS_EN
        .i_wdata   (wdata),
`endif
        .i_rd_rdy  (rd_rdy),
        .o_rd_ack  (rd_ack),
        .i_rd_idx  (rd_idx),
        .o_dat_rdy (dat_rdy),
        .i_dat_ack (dat_ack),
        .o_dat     (dat),
        .o_dat_err (dat_err),
        .o_fill    (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_entries();
        for (int k = 0; k < TBUF; k++)
            for (int l = 0; l < VSIZE; l++)
                rdatas[k][l] = 8'h10 + 8'(k);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; we = 1'b0; rd_rdy = 1'b0; rd_idx = '0; dat_ack = 1'b0;
        wdata = '0;
        set_entries();
        tick(2);
        check("rst_dat_rdy", 32'(dat_rdy), 32'd0);
        check("rst_dat",     dat,          32'h0);
        check("rst_err",     32'(dat_err), 32'd0);
        check("rst_fill",    32'(fill),    32'd0);
        rst_n = 1'b1;
        tick();

        // 1: read with empty buffer
        rd_rdy = 1'b1; rd_idx = 2'd0; dat_ack = 1'b1;
        #1 check("t1_ack", 32'(rd_ack), 32'd1);
        tick();
        rd_rdy = 1'b0;
        check("t1_rdy",  32'(dat_rdy), 32'd1);
        check("t1_err",  32'(dat_err), 32'd1);
        check("t1_dat",  dat,          32'h10101010);
        check("t1_fill", 32'(fill),    32'd0);
        tick();
        check("t1_drop", 32'(dat_rdy), 32'd0);

        // 2: three shifts, back-to-back reads
        we = 1'b1; tick(3); we = 1'b0;
        check("t2_fill", 32'(fill), 32'd3);
        rd_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd_idx = 2'(k);
            tick();
            check($sformatf("t2_rdy%0d", k), 32'(dat_rdy), 32'd1);
            check($sformatf("t2_dat%0d", k), dat, {4{8'h10 + 8'(k)}});
            check($sformatf("t2_err%0d", k), 32'(dat_err), (k == 3) ? 32'd1 : 32'd0);
        end
        rd_rdy = 1'b0; tick();

        // 3: saturation
        we = 1'b1; tick(6); we = 1'b0;
        check("t3_fill", 32'(fill), 32'd4);
        rd_rdy = 1'b1; rd_idx = 2'd3; tick(); rd_rdy = 1'b0;
        check("t3_err", 32'(dat_err), 32'd0);
        check("t3_dat", dat, 32'h13131313);
        tick();

        // 4: backpressure
        rd_rdy = 1'b1; rd_idx = 2'd1; dat_ack = 1'b0; tick();
        rd_idx = 2'd2;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_ack%0d", i), 32'(rd_ack), 32'd0);
            tick();
            check($sformatf("t4_dat%0d", i), dat, 32'h11111111);
            check($sformatf("t4_rdy%0d", i), 32'(dat_rdy), 32'd1);
        end
        dat_ack = 1'b1;
        #1 check("t4_ack_rel", 32'(rd_ack), 32'd1);
        tick();
        rd_rdy = 1'b0;
        check("t4_new", dat, 32'h12121212);
        tick();

        // 5: read coincident with shift
        for (int l = 0; l < VSIZE; l++) begin rdatas[0][l] = 8'h55; wdata[l] = 8'hAA; end
        we = 1'b1; rd_rdy = 1'b1; rd_idx = 2'd0; tick();
        we = 1'b0; rd_rdy = 1'b0;
`ifdef SIMD_TMP_READER_BYPASS_EN
        check("t5_dat", dat, 32'hAAAAAAAA);
`else
        check("t5_dat", dat, 32'h55555555);
`endif
        check("t5_err", 32'(dat_err), 32'd0);
        set_entries();
        tick();

        // 6: clear with accepted read
        clear = 1'b1; rd_rdy = 1'b1; rd_idx = 2'd2; tick();
        clear = 1'b0;
        check("t6_err",  32'(dat_err), 32'd0);
        check("t6_dat",  dat,          32'h12121212);
        check("t6_fill", 32'(fill),    32'd0);
        rd_idx = 2'd0; tick(); rd_rdy = 1'b0;
        check("t6_err0", 32'(dat_err), 32'd1);
        check("t6_rdy",  32'(dat_rdy), 32'd1);
        tick();

        // 7: asynchronous reset mid-operation
        we = 1'b1; rd_rdy = 1'b1; dat_ack = 1'b0; tick(); we = 1'b0;
        check("t7_pre_rdy",  32'(dat_rdy), 32'd1);
        check("t7_pre_fill", 32'(fill),    32'd1);
        #2 rst_n = 1'b0;
        #1 check("t7_rdy",  32'(dat_rdy), 32'd0);
        check("t7_fill", 32'(fill), 32'd0);
        check("t7_ack",  32'(rd_ack), 32'd1);
        rst_n = 1'b1; rd_rdy = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
